lsu_mem_stage: RTL and testbench

//  Parametrised, multi-cycle load/store unit for the MEM stage. Successor to the

---
 rtl/lsu_mem_if.sv | 42 ++++
 rtl/lsu_mem_stage.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if.sv
// Request/response and data-memory port bundle for the MEM-stage load/store unit.
// The LSU sits on the slave modport; the pipeline and memory model sit on the master side.
interface lsu_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_ren;
  logic              req_wen;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;

  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_ren;
  logic              dmem_wen;
  logic [DATA_W-1:0] dmem_wdata;
  logic [LANES-1:0]  dmem_mask;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport slave (
    input  req_valid, req_ren, req_wen, funct3, addr, wdata, dmem_rdata, dmem_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           dmem_addr, dmem_ren, dmem_wen, dmem_wdata, dmem_mask
  );

  modport master (
    output req_valid, req_ren, req_wen, funct3, addr, wdata, dmem_rdata, dmem_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           dmem_addr, dmem_ren, dmem_wen, dmem_wdata, dmem_mask
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Multi-cycle MEM-stage load/store unit: registers one request, lane-aligns it onto the
// data-memory port, waits for a variable-latency ack (with timeout) and extends load data.
module lsu_mem_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
)(
  input  logic      i_clk,
  input  logic      i_rst_n,
  lsu_mem_if.slave  bus
);
  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [OFS_W-1:0] off;
    logic [2:0]       f3;
    logic             ren;
  } req_t;

  state_t            state, state_nx;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept, illegal, misal, to_hit;
  logic [OFS_W-1:0]  off_in;
  logic [LANES-1:0]  size_mask;
  logic [DATA_W-1:0] ld_sh, ld_ext;

  logic              rsp_valid_q, rsp_err_q, rsp_to_q, ren_q, wen_q;
  logic [DATA_W-1:0] rsp_rdata_q, wdata_q;
  logic [LANES-1:0]  mask_q;
  logic [ADDR_W-1:0] addr_q;

  // Ready is gated by reset so the pipeline never sees a grant while the unit is held.
  assign bus.req_ready = (state == IDLE) && i_rst_n;
  assign accept        = bus.req_valid && bus.req_ready;
  assign off_in        = bus.addr[OFS_W-1:0];
  assign to_hit        = (TIMEOUT_CYC != 0) && (cnt == TO_LIM);

  always_comb begin
    illegal = (bus.req_ren == bus.req_wen) ||
              (bus.req_wen && bus.funct3[2]) ||
              (bus.funct3 == 3'b111) ||
              ((DATA_W == 32) && ((bus.funct3[1:0] == 2'b11) || (bus.funct3 == 3'b110)));
    misal     = 1'b0;
    size_mask = '0;
    case (bus.funct3[1:0])
      2'b00: size_mask[0] = 1'b1;
      2'b01: begin size_mask[1:0] = 2'b11; misal = off_in[0];     end
      2'b10: begin size_mask[3:0] = 4'hF;  misal = |off_in[1:0];  end
      default: begin size_mask = '1;       misal = |off_in;       end
    endcase
  end

  always_comb begin
    ld_sh  = bus.dmem_rdata >> {req_q.off, 3'b000};
    ld_ext = ld_sh;
    case (req_q.f3[1:0])
      2'b00:   ld_ext = req_q.f3[2] ? DATA_W'(ld_sh[7:0])  : DATA_W'($signed(ld_sh[7:0]));
      2'b01:   ld_ext = req_q.f3[2] ? DATA_W'(ld_sh[15:0]) : DATA_W'($signed(ld_sh[15:0]));
      2'b10:   ld_ext = req_q.f3[2] ? DATA_W'(ld_sh[31:0]) : DATA_W'($signed(ld_sh[31:0]));
      default: ld_ext = ld_sh;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (illegal || misal) ? RESP : ACCESS;
      ACCESS:  if (bus.dmem_ack || to_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q       <= '0;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // Response fields are single-cycle; anything not re-set below returns to zero.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: if (accept) begin
          req_q.off <= off_in;
          req_q.f3  <= bus.funct3;
          req_q.ren <= bus.req_ren;
          cnt       <= CNT_W'(1);
          addr_q    <= {bus.addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          wdata_q   <= bus.wdata << {off_in, 3'b000};
          mask_q    <= size_mask << off_in;
          if (illegal || misal) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            ren_q <= bus.req_ren;
            wen_q <= bus.req_wen;
          end
        end
        ACCESS: begin
          if (bus.dmem_ack) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= req_q.ren ? ld_ext : '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
          end else if (to_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_to_q    <= 1'b1;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.busy        = (state != IDLE);
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_ren    = ren_q;
  assign bus.dmem_wen    = wen_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.dmem_mask   = mask_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a 32-bit unit with a short timeout and a 64-bit unit,
// expected responses queued when stimulus is driven and popped when the DUT responds.
module tb_lsu_mem_stage;
  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  lsu_mem_if #(.DATA_W(32), .ADDR_W(32)) if32();
  lsu_mem_if #(.DATA_W(64), .ADDR_W(32)) if64();

  lsu_mem_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u32 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if32));
  lsu_mem_stage #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(16)) u64 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if64));

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t exp32[$];
  exp_t exp64[$];
  int checks = 0, failures = 0;
  int cyc = 0, rsp_cnt32 = 0, rsp_cnt64 = 0, ren_cyc32 = 0, pops32 = 0, pops64 = 0;

  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) begin
    if (if32.rsp_valid) rsp_cnt32 <= rsp_cnt32 + 1;
    if (if64.rsp_valid) rsp_cnt64 <= rsp_cnt64 + 1;
    if (if32.dmem_ren)  ren_cyc32 <= ren_cyc32 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Presents one request at posedge+1 and returns 1 time unit after the accepting edge.
  task automatic send32(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!if32.req_ready && n < 20) begin @(posedge i_clk); #1; n++; end
    checks++;
    if (if32.req_ready !== 1'b1) begin
      failures++; $display("FAIL send32_ready got=%b required=1", if32.req_ready);
    end
    if32.req_valid = 1'b1; if32.req_ren = ren; if32.req_wen = wen;
    if32.funct3 = f3; if32.addr = a; if32.wdata = wd;
    @(posedge i_clk); #1;
    if32.req_valid = 1'b0;
  endtask

  task automatic send64(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] a, input logic [63:0] wd);
    int n = 0;
    while (!if64.req_ready && n < 20) begin @(posedge i_clk); #1; n++; end
    checks++;
    if (if64.req_ready !== 1'b1) begin
      failures++; $display("FAIL send64_ready got=%b required=1", if64.req_ready);
    end
    if64.req_valid = 1'b1; if64.req_ren = ren; if64.req_wen = wen;
    if64.funct3 = f3; if64.addr = a; if64.wdata = wd;
    @(posedge i_clk); #1;
    if64.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({if32.req_ready, if32.busy, if32.rsp_valid, if32.dmem_ren, if32.dmem_wen,
         if32.dmem_mask, if32.dmem_addr, if32.rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b busy=%b v=%b ren=%b wen=%b mask=%h addr=%h rd=%h required all 0",
               if32.req_ready, if32.busy, if32.rsp_valid, if32.dmem_ren, if32.dmem_wen,
               if32.dmem_mask, if32.dmem_addr, if32.rsp_rdata);
    end
    checks++;
    if ({if64.req_ready, if64.busy, if64.dmem_mask} !== '0) begin
      failures++; $display("FAIL reset64 got ready=%b busy=%b mask=%h required 0",
                           if64.req_ready, if64.busy, if64.dmem_mask);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if ({if32.req_ready, if32.busy, if64.req_ready} !== 3'b101) begin
      failures++; $display("FAIL reset_release got ready=%b busy=%b ready64=%b required 1 0 1",
                           if32.req_ready, if32.busy, if64.req_ready);
    end
  endtask

  task automatic test_load_byte();
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      send32(1'b1, 1'b0, {u[0], 2'b00}, 32'h0000_0103, 32'h0);
      checks++;
      if ({if32.dmem_addr, if32.dmem_mask, if32.dmem_ren, if32.dmem_wen, if32.rsp_valid} !==
          {32'h0000_0100, 4'b1000, 1'b1, 1'b0, 1'b0}) begin
        failures++; $display("FAIL lb_access u=%0d got addr=%h mask=%b ren=%b wen=%b v=%b required 100 1000 1 0 0",
                             u, if32.dmem_addr, if32.dmem_mask, if32.dmem_ren, if32.dmem_wen, if32.rsp_valid);
      end
      if32.dmem_ack = 1'b1; if32.dmem_rdata = 32'h80FF_1234;
      exp32.push_back('{(u != 0) ? 64'h0000_0080 : 64'hFFFF_FF80, 1'b0, 1'b0});
      @(posedge i_clk); #1;
      if32.dmem_ack = 1'b0;
      e = exp32.pop_front(); pops32++; checks++;
      if ({if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout} !== {1'b1, e.rdata[31:0], e.err, e.to}) begin
        failures++; $display("FAIL lb_rsp u=%0d got v=%b d=%h e=%b t=%b required v=1 d=%h e=%b t=%b",
                             u, if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, e.rdata[31:0], e.err, e.to);
      end
      @(posedge i_clk); #1;
      checks++;
      if ({if32.rsp_valid, if32.rsp_rdata, if32.req_ready, if32.busy} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
        failures++; $display("FAIL lb_after u=%0d got v=%b d=%h ready=%b busy=%b required 0 0 1 0",
                             u, if32.rsp_valid, if32.rsp_rdata, if32.req_ready, if32.busy);
      end
    end
  endtask

  task automatic test_store_half();
    exp_t e;
    send32(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({if32.dmem_addr, if32.dmem_wdata, if32.dmem_mask, if32.dmem_wen, if32.dmem_ren, if32.rsp_valid} !==
          {32'h0000_0100, 32'hABCD_0000, 4'b1100, 1'b1, 1'b0, 1'b0}) begin
        failures++; $display("FAIL sh_access k=%0d got addr=%h wd=%h mask=%b wen=%b ren=%b v=%b required 100 abcd0000 1100 1 0 0",
                             k, if32.dmem_addr, if32.dmem_wdata, if32.dmem_mask, if32.dmem_wen, if32.dmem_ren, if32.rsp_valid);
      end
      if (k < 2) begin @(posedge i_clk); #1; end
    end
    if32.dmem_ack = 1'b1; if32.dmem_rdata = 32'hFFFF_FFFF;
    exp32.push_back('{64'h0, 1'b0, 1'b0});
    @(posedge i_clk); #1;
    if32.dmem_ack = 1'b0;
    e = exp32.pop_front(); pops32++; checks++;
    if ({if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, if32.dmem_wen} !==
        {1'b1, e.rdata[31:0], e.err, e.to, 1'b0}) begin
      failures++; $display("FAIL sh_rsp got v=%b d=%h e=%b t=%b wen=%b required v=1 d=%h e=%b t=%b wen=0",
                           if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, if32.dmem_wen, e.rdata[31:0], e.err, e.to);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_errors();
    exp_t e;
    int base;
    logic        rens[6];
    logic        wens[6];
    logic [2:0]  f3s[6];
    logic [31:0] adrs[6];
    rens = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    wens = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    f3s  = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110};
    adrs = '{32'h101, 32'h103, 32'h100, 32'h100, 32'h100, 32'h100};
    base = ren_cyc32;
    for (int i = 0; i < 6; i++) begin
      send32(rens[i], wens[i], f3s[i], adrs[i], 32'h1234_5678);
      exp32.push_back('{64'h0, 1'b1, 1'b0});
      e = exp32.pop_front(); pops32++; checks++;
      if ({if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, if32.dmem_ren, if32.dmem_wen} !==
          {1'b1, e.rdata[31:0], e.err, e.to, 2'b00}) begin
        failures++; $display("FAIL err_rsp i=%0d got v=%b d=%h e=%b t=%b ren=%b wen=%b required v=1 d=0 e=1 t=0 strobes 0",
                             i, if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, if32.dmem_ren, if32.dmem_wen);
      end
      @(posedge i_clk); #1;
      checks++;
      if ({if32.rsp_valid, if32.rsp_err, if32.busy} !== 3'b000) begin
        failures++; $display("FAIL err_after i=%0d got v=%b e=%b busy=%b required 0 0 0",
                             i, if32.rsp_valid, if32.rsp_err, if32.busy);
      end
    end
    checks++;
    if (ren_cyc32 != base) begin
      failures++; $display("FAIL err_no_ren got ren_cycles=%0d required %0d", ren_cyc32, base);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int base;
    send32(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
    exp32.push_back('{64'h0, 1'b0, 1'b1});
    repeat (3) begin @(posedge i_clk); #1; end
    checks++;
    if ({if32.dmem_ren, if32.rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL to_cycle4 got ren=%b v=%b required 1 0", if32.dmem_ren, if32.rsp_valid);
    end
    @(posedge i_clk); #1;
    e = exp32.pop_front(); pops32++; checks++;
    if ({if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, if32.dmem_ren} !==
        {1'b1, e.rdata[31:0], e.err, e.to, 1'b0}) begin
      failures++; $display("FAIL to_rsp got v=%b d=%h e=%b t=%b ren=%b required v=1 d=0 e=0 t=1 ren=0",
                           if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, if32.dmem_ren);
    end
    @(posedge i_clk); #1;
    base = rsp_cnt32;
    if32.dmem_ack = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end
    checks++;
    if ({if32.busy, if32.req_ready} !== 2'b01) begin
      failures++; $display("FAIL late_ack_state got busy=%b ready=%b required 0 1", if32.busy, if32.req_ready);
    end
    if32.dmem_ack = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (rsp_cnt32 != base) begin
      failures++; $display("FAIL late_ack_rsp got pulses=%0d required %0d", rsp_cnt32, base);
    end
    send32(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0);
    repeat (3) begin @(posedge i_clk); #1; end
    if32.dmem_ack = 1'b1; if32.dmem_rdata = 32'h1234_5678;
    exp32.push_back('{64'h1234_5678, 1'b0, 1'b0});
    @(posedge i_clk); #1;
    if32.dmem_ack = 1'b0;
    e = exp32.pop_front(); pops32++; checks++;
    if ({if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout} !== {1'b1, e.rdata[31:0], e.err, e.to}) begin
      failures++; $display("FAIL ack4_rsp got v=%b d=%h e=%b t=%b required v=1 d=%h e=%b t=%b",
                           if32.rsp_valid, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, e.rdata[31:0], e.err, e.to);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset_mid_access();
    int base;
    send32(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D);
    checks++;
    if (if32.dmem_wen !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got wen=%b required 1", if32.dmem_wen);
    end
    base = rsp_cnt32;
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({if32.dmem_wen, if32.dmem_ren, if32.busy, if32.req_ready} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_async got wen=%b ren=%b busy=%b ready=%b required 0 0 0 0",
                           if32.dmem_wen, if32.dmem_ren, if32.busy, if32.req_ready);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if ({if32.req_ready, if32.busy} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_release got ready=%b busy=%b required 1 0", if32.req_ready, if32.busy);
    end
    @(posedge i_clk); #1;
    checks++;
    if (rsp_cnt32 != base) begin
      failures++; $display("FAIL rst_mid_no_rsp got pulses=%0d required %0d", rsp_cnt32, base);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acc[$];
    logic took;
    int   nacc = 0;
    if32.req_valid = 1'b1; if32.req_ren = 1'b1; if32.req_wen = 1'b0;
    if32.funct3 = 3'b010; if32.addr = 32'h400; if32.wdata = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (if32.rsp_valid) begin
        checks++;
        if (exp32.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected got rsp d=%h required no response", if32.rsp_rdata);
        end else begin
          e = exp32.pop_front(); pops32++;
          if ({if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout} !== {e.rdata[31:0], e.err, e.to}) begin
            failures++; $display("FAIL b2b_rsp c=%0d got d=%h e=%b t=%b required d=%h e=%b t=%b",
                                 c, if32.rsp_rdata, if32.rsp_err, if32.rsp_timeout, e.rdata[31:0], e.err, e.to);
          end
        end
      end
      took = if32.req_valid && if32.req_ready;
      if (if32.dmem_ren || if32.dmem_wen) begin
        if32.dmem_ack   = 1'b1;
        if32.dmem_rdata = 32'hB000_0000 | 32'(c);
        exp32.push_back('{if32.dmem_ren ? {32'h0, if32.dmem_rdata} : 64'h0, 1'b0, 1'b0});
      end else begin
        if32.dmem_ack = 1'b0;
      end
      @(posedge i_clk); #1;
      if (took) begin
        acc.push_back(cyc);
        nacc++;
        if (nacc == 4) if32.req_valid = 1'b0;
        else begin
          if32.req_ren = nacc[0] ? 1'b0 : 1'b1;
          if32.req_wen = nacc[0];
          if32.addr    = 32'h400 + 32'(4 * nacc);
          if32.wdata   = 32'h5A5A_0000 | 32'(nacc);
        end
      end
    end
    if32.dmem_ack = 1'b0; if32.req_valid = 1'b0;
    checks++;
    if (acc.size() != 4) begin
      failures++; $display("FAIL b2b_accepts got=%0d required 4", acc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc[i] - acc[i-1] != 3) begin
          failures++; $display("FAIL b2b_gap i=%0d got=%0d required 3", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_dw64();
    exp_t e;
    logic [2:0]  f3s[3];
    logic [31:0] adrs[3];
    logic [7:0]  masks[3];
    logic [63:0] rds[3];
    logic [63:0] exps[3];
    f3s   = '{3'b011, 3'b110, 3'b010};
    adrs  = '{32'h8, 32'hC, 32'hC};
    masks = '{8'hFF, 8'hF0, 8'hF0};
    rds   = '{64'h8000_0000_0000_0001, 64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5678};
    exps  = '{64'h8000_0000_0000_0001, 64'h0000_0000_DEAD_BEEF, 64'hFFFF_FFFF_DEAD_BEEF};
    for (int i = 0; i < 3; i++) begin
      send64(1'b1, 1'b0, f3s[i], adrs[i], 64'h0);
      checks++;
      if ({if64.dmem_addr, if64.dmem_mask, if64.dmem_ren} !== {32'h8, masks[i], 1'b1}) begin
        failures++; $display("FAIL d64_access i=%0d got addr=%h mask=%h ren=%b required 8 %h 1",
                             i, if64.dmem_addr, if64.dmem_mask, if64.dmem_ren, masks[i]);
      end
      if64.dmem_ack = 1'b1; if64.dmem_rdata = rds[i];
      exp64.push_back('{exps[i], 1'b0, 1'b0});
      @(posedge i_clk); #1;
      if64.dmem_ack = 1'b0;
      e = exp64.pop_front(); pops64++; checks++;
      if ({if64.rsp_valid, if64.rsp_rdata, if64.rsp_err, if64.rsp_timeout} !== {1'b1, e.rdata, e.err, e.to}) begin
        failures++; $display("FAIL d64_rsp i=%0d got v=%b d=%h e=%b t=%b required v=1 d=%h e=%b t=%b",
                             i, if64.rsp_valid, if64.rsp_rdata, if64.rsp_err, if64.rsp_timeout, e.rdata, e.err, e.to);
      end
      @(posedge i_clk); #1;
    end
    send64(1'b1, 1'b0, 3'b011, 32'h4, 64'h0);
    exp64.push_back('{64'h0, 1'b1, 1'b0});
    e = exp64.pop_front(); pops64++; checks++;
    if ({if64.rsp_valid, if64.rsp_err, if64.rsp_rdata, if64.dmem_ren} !== {1'b1, e.err, e.rdata, 1'b0}) begin
      failures++; $display("FAIL d64_misaligned got v=%b e=%b d=%h ren=%b required v=1 e=1 d=0 ren=0",
                           if64.rsp_valid, if64.rsp_err, if64.rsp_rdata, if64.dmem_ren);
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    if32.req_valid = 1'b0; if32.req_ren = 1'b0; if32.req_wen = 1'b0; if32.funct3 = 3'b0;
    if32.addr = '0; if32.wdata = '0; if32.dmem_rdata = '0; if32.dmem_ack = 1'b0;
    if64.req_valid = 1'b0; if64.req_ren = 1'b0; if64.req_wen = 1'b0; if64.funct3 = 3'b0;
    if64.addr = '0; if64.wdata = '0; if64.dmem_rdata = '0; if64.dmem_ack = 1'b0;

    test_reset();
    test_load_byte();
    test_store_half();
    test_errors();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_dw64();

    repeat (2) begin @(posedge i_clk); #1; end
    checks++;
    if (exp32.size() != 0 || rsp_cnt32 != pops32) begin
      failures++; $display("FAIL sb32_drain got pending=%0d pulses=%0d required pending=0 pulses=%0d",
                           exp32.size(), rsp_cnt32, pops32);
    end
    checks++;
    if (exp64.size() != 0 || rsp_cnt64 != pops64) begin
      failures++; $display("FAIL sb64_drain got pending=%0d pulses=%0d required pending=0 pulses=%0d",
                           exp64.size(), rsp_cnt64, pops64);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
